// File: rtl/float_vector_source.sv
// float_vector_source
// IEEE-754 single-precision vector stimulus generator. Fills a VLEN-element
// vector one element per clock from a fixed test table, an LFSR-driven stream
// of finite normal floats, or a table of IEEE special values. It then offers
// the finished vector through a valid/ready handshake and counts accepted vectors.

module float_vector_source #(
  parameter int          VLEN  = 4,
  parameter int          START = 0,
  parameter logic [31:0] SEED  = 32'hACE1_2024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [1:0]        mode,
  input  logic              vec_ready,
  output logic [32*VLEN-1:0] vec,
  output logic              vec_valid,
  output logic [15:0]       vec_count
);

  // Element tracker width; a one-element vector still needs a 1-bit tracker.
  localparam int IDX_W = (VLEN > 1) ? $clog2(VLEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VLEN - 1);

  // Out-of-range start index and an all-zero seed fall back to safe values;
  // an all-zero Galois LFSR would lock up.
  localparam logic [3:0]  TPTR_INIT = ((START >= 0) && (START <= 10)) ? 4'(START) : 4'd0;
  localparam logic [31:0] SEED_INIT = (SEED == 32'd0) ? 32'hACE1_2024 : SEED;

  // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form.
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  // Source encodings held in src_r (reserved mode 3 is folded to the table).
  localparam logic [1:0] SRC_TABLE   = 2'd0;
  localparam logic [1:0] SRC_RANDOM  = 2'd1;
  localparam logic [1:0] SRC_SPECIAL = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t              state_r;
  logic [1:0]          src_r;
  logic [IDX_W-1:0]    idx_r;
  logic [3:0]          tptr_r;
  logic [2:0]          sptr_r;
  logic [31:0]         lfsr_r;
  logic [32*VLEN-1:0]  vec_r;
  logic                valid_r;
  logic [15:0]         count_r;

  logic [31:0]         gen_word_s;
  logic                last_elem_s;

  // Fixed 11-entry test table.
  function automatic logic [31:0] table_word(input logic [3:0] idx);
    logic [31:0] w;
    case (idx)
      4'd0:    w = 32'h404C_CCCC;  //  3.2
      4'd1:    w = 32'h4086_6666;  //  4.2
      4'd2:    w = 32'h3F28_F5C2;  //  0.66
      4'd3:    w = 32'h3F02_8F5C;  //  0.51
      4'd4:    w = 32'hBF00_0000;  // -0.5
      4'd5:    w = 32'hC0CC_CCCC;  // -6.4
      4'd6:    w = 32'h3E00_0000;  //  0.125
      4'd7:    w = 32'h41CC_CCCC;  //  25.6
      4'd8:    w = 32'hBDCC_CCCC;  // -0.1
      4'd9:    w = 32'h0000_0000;  //  0.0
      4'd10:   w = 32'h7F80_0000;  // +inf
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  // IEEE special values: +/-0, +/-inf, qNaN, min subnormal, max normal, min normal.
  function automatic logic [31:0] special_word(input logic [2:0] idx);
    logic [31:0] w;
    case (idx)
      3'd0:    w = 32'h0000_0000;
      3'd1:    w = 32'h8000_0000;
      3'd2:    w = 32'h7F80_0000;
      3'd3:    w = 32'hFF80_0000;
      3'd4:    w = 32'h7FC0_0000;
      3'd5:    w = 32'h0000_0001;
      3'd6:    w = 32'h7F7F_FFFF;
      3'd7:    w = 32'h0080_0000;
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  // Random word: exponent biased into 120..135 so the value is always a
  // finite normal number.
  function automatic logic [31:0] random_word(input logic       sign,
                                              input logic [3:0] exp_lo,
                                              input logic [22:0] man);
    logic [7:0] exp_v;
    exp_v = 8'd120 + {4'd0, exp_lo};
    return {sign, exp_v, man};
  endfunction

  // One right shift of the Galois LFSR.
  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    logic [31:0] n;
    if (l[0]) begin
      n = (l >> 1) ^ LFSR_MASK;
    end else begin
      n = l >> 1;
    end
    return n;
  endfunction

  // Reserved mode 3 behaves as the test table.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    logic [1:0] r;
    if (m == 2'd3) begin
      r = SRC_TABLE;
    end else begin
      r = m;
    end
    return r;
  endfunction

  // Word produced by the currently latched source.
  always_comb begin
    gen_word_s = 32'd0;
    case (src_r)
      SRC_TABLE:   gen_word_s = table_word(tptr_r);
      SRC_RANDOM:  gen_word_s = random_word(lfsr_r[31], lfsr_r[26:23], lfsr_r[22:0]);
      SRC_SPECIAL: gen_word_s = special_word(sptr_r);
      default:     gen_word_s = table_word(tptr_r);
    endcase
  end

  // Flag for the element whose write completes the vector.
  always_comb begin
    if (idx_r == LAST_IDX) begin
      last_elem_s = 1'b1;
    end else begin
      last_elem_s = 1'b0;
    end
  end

  // Fill/hold sequencer with source pointers, vector register and counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      src_r   <= SRC_TABLE;
      idx_r   <= '0;
      tptr_r  <= TPTR_INIT;
      sptr_r  <= 3'd0;
      lfsr_r  <= SEED_INIT;
      vec_r   <= '0;
      valid_r <= 1'b0;
      count_r <= 16'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (run) begin
            src_r   <= norm_mode(mode);
            idx_r   <= '0;
            state_r <= ST_FILL;
          end
        end

        ST_FILL: begin
          for (int i = 0; i < VLEN; i++) begin
            if (idx_r == IDX_W'(i)) begin
              vec_r[32*i +: 32] <= gen_word_s;
            end
          end
          // Only the active source moves; the others keep their position.
          case (src_r)
            SRC_RANDOM:  lfsr_r <= lfsr_next(lfsr_r);
            SRC_SPECIAL: sptr_r <= sptr_r + 3'd1;
            default:     tptr_r <= (tptr_r == 4'd10) ? 4'd0 : (tptr_r + 4'd1);
          endcase
          if (last_elem_s) begin
            idx_r   <= '0;
            valid_r <= 1'b1;
            state_r <= ST_HOLD;
          end else begin
            idx_r   <= idx_r + IDX_W'(1);
          end
        end

        ST_HOLD: begin
          if (vec_ready) begin
            count_r <= count_r + 16'd1;
            valid_r <= 1'b0;
            idx_r   <= '0;
            if (run) begin
              src_r   <= norm_mode(mode);
              state_r <= ST_FILL;
            end else begin
              state_r <= ST_IDLE;
            end
          end
        end

        default: begin
          state_r <= ST_IDLE;
          valid_r <= 1'b0;
          idx_r   <= '0;
        end
      endcase
    end
  end

  assign vec       = vec_r;
  assign vec_valid = valid_r;
  assign vec_count = count_r;

endmodule
